// File: rtl/irq_pkg.sv
// Shared constants, state encoding and register layouts for the interrupt controller.
package irq_pkg;

  localparam int unsigned NSRC_DEF = 6;
  localparam int unsigned ID_W     = 3;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 3;

  localparam logic [ADDR_W-1:0] OFF_PEND = 3'd0;
  localparam logic [ADDR_W-1:0] OFF_MASK = 3'd1;
  localparam logic [ADDR_W-1:0] OFF_MODE = 3'd2;
  localparam logic [ADDR_W-1:0] OFF_CTRL = 3'd3;
  localparam logic [ADDR_W-1:0] OFF_VEC  = 3'd4;
  localparam logic [ADDR_W-1:0] OFF_EOI  = 3'd5;
  localparam logic [ADDR_W-1:0] OFF_STAT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [27:0]     rsvd;
    logic [ID_W-1:0] id;
  } vec_t;

  typedef struct packed {
    logic [22:0]     rsvd2;
    logic            err;
    logic [1:0]      rsvd1;
    state_e          state;
    logic            rsvd0;
    logic [ID_W-1:0] isr_id;
  } stat_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder; search starts at base when rot is set, else at 0.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEF
) (
  input  logic [NSRC-1:0] req,
  input  logic [ID_W-1:0] base,
  input  logic            rot,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  int unsigned start;
  int unsigned k;

  // Walk from the farthest slot back to the start so the nearest request wins.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    start = rot ? 32'(base) : 32'd0;
    k     = 32'd0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      k = start + (NSRC - 32'd1 - i);
      if (k >= NSRC) k = k - NSRC;
      if (req[k]) begin
        valid = 1'b1;
        id    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: register file, edge/level capture, winner select and
// the assert/claim/EOI handshake towards the CPU.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic [NSRC-1:0]   src_irq,
  output logic              irq_out
);

  logic [NSRC-1:0] pend, mask, mode, prev, qual, clr_vec, pend_nxt;
  logic [1:0]      ctrl;
  logic [ID_W-1:0] base, base_nxt, isr_id, win_id;
  logic            err, win_valid;
  state_e          state, state_nxt;

  logic wr_pend, wr_mask, wr_mode, wr_ctrl, wr_stat, claim, eoi, eoi_match;
  logic claim_take, eoi_take, err_set;
  logic unused_din;

  assign wr_pend   = we && (addr == OFF_PEND);
  assign wr_mask   = we && (addr == OFF_MASK);
  assign wr_mode   = we && (addr == OFF_MODE);
  assign wr_ctrl   = we && (addr == OFF_CTRL);
  assign claim     = we && (addr == OFF_VEC);
  assign eoi       = we && (addr == OFF_EOI);
  assign wr_stat   = we && (addr == OFF_STAT);
  assign eoi_match = (din[ID_W-1:0] == isr_id);
  assign unused_din = ^din;

  assign qual = pend & mask & {NSRC{ctrl[0]}};

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (qual),
    .base  (base),
    .rot   (ctrl[1]),
    .valid (win_valid),
    .id    (win_id)
  );

  // State register; irq_out tracks the state being entered so it is high exactly in ASSERT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      irq_out <= (state_nxt == ST_ASSERT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|qual) state_nxt = ST_ASSERT;
      ST_ASSERT: begin
        if (claim && win_valid) state_nxt = ST_SERVICE;
        else if (!(|qual))      state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (eoi && eoi_match) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake qualifiers and next pending vector; a same-cycle edge set beats any clear.
  always_comb begin
    claim_take = claim && (state == ST_ASSERT) && win_valid;
    eoi_take   = eoi && (state == ST_SERVICE) && eoi_match;
    err_set    = (claim && !claim_take) || (eoi && !eoi_take);
    clr_vec    = '0;
    if (wr_pend)    clr_vec = clr_vec | din[NSRC-1:0];
    if (claim_take) clr_vec = clr_vec | (NSRC'(1) << win_id);
    pend_nxt   = (~mode & src_irq) |
                 (mode & ((src_irq & ~prev) | (pend & ~clr_vec)));
    base_nxt   = ((32'(isr_id) + 32'd1) >= NSRC) ? '0 : ID_W'(isr_id + 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      mask   <= '0;
      mode   <= '0;
      ctrl   <= '0;
      prev   <= '0;
      base   <= '0;
      isr_id <= '0;
      err    <= 1'b0;
    end else begin
      pend <= pend_nxt;
      prev <= src_irq;
      if (wr_mask)    mask   <= din[NSRC-1:0];
      if (wr_mode)    mode   <= din[NSRC-1:0];
      if (wr_ctrl)    ctrl   <= din[1:0];
      if (claim_take) isr_id <= win_id;
      if (eoi_take)   base   <= base_nxt;
      if (err_set)      err <= 1'b1;
      else if (wr_stat) err <= 1'b0;
    end
  end

  // Read mux; VEC and STAT reads have no side effects.
  always_comb begin
    vec_t  v;
    stat_t s;
    v        = '0;
    v.valid  = win_valid;
    v.id     = win_id;
    s        = '0;
    s.err    = err;
    s.state  = state;
    s.isr_id = isr_id;
    case (addr)
      OFF_PEND: dout = DATA_W'(pend);
      OFF_MASK: dout = DATA_W'(mask);
      OFF_MODE: dout = DATA_W'(mode);
      OFF_CTRL: dout = DATA_W'(ctrl);
      OFF_VEC:  dout = v;
      OFF_STAT: dout = s;
      default:  dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with a queue-based scoreboard.
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int unsigned N = 6;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic [N-1:0]      src_irq;
  logic              irq_out;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  irq_ctrl #(.NSRC(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .src_irq (src_irq),
    .irq_out (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0x%08h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] v);
    push_exp(tag, v);
    addr = a;
    #1;
    pop_cmp(dout);
  endtask

  task automatic chk_irq(input string tag, input logic v);
    push_exp(tag, 32'(v));
    pop_cmp(32'(irq_out));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    din  = '0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; we = 1'b0; din = '0; src_irq = '0;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset state
    chk_irq("rst_irq", 1'b0);
    chk_reg("rst_pend", OFF_PEND, 32'h0);
    chk_reg("rst_mask", OFF_MASK, 32'h0);
    chk_reg("rst_stat", OFF_STAT, 32'h0);

    // Timer edge on source 0
    bus_write(OFF_MODE, 32'h01);
    bus_write(OFF_MASK, 32'h01);
    bus_write(OFF_CTRL, 32'h01);
    src_irq = 6'h01;
    step(1);
    src_irq = 6'h00;
    chk_reg("t1_pend", OFF_PEND, 32'h1);
    chk_irq("t1_irq_lat1", 1'b0);
    step(1);
    chk_irq("t1_irq_lat2", 1'b1);
    chk_reg("t1_vec", OFF_VEC, 32'h8000_0000);
    bus_write(OFF_VEC, 32'h0);
    chk_irq("t1_claim_irq", 1'b0);
    chk_reg("t1_claim_stat", OFF_STAT, 32'h20);
    bus_write(OFF_EOI, 32'h0);
    chk_reg("t1_eoi_stat", OFF_STAT, 32'h00);
    chk_reg("t1_eoi_pend", OFF_PEND, 32'h0);
    step(1);
    chk_irq("t1_idle_irq", 1'b0);

    // Fixed priority, sources 2 and 5
    bus_write(OFF_MODE, 32'h25);
    bus_write(OFF_MASK, 32'h24);
    src_irq = 6'h24;
    step(1);
    src_irq = 6'h00;
    chk_reg("t2_pend", OFF_PEND, 32'h24);
    step(1);
    chk_irq("t2_irq", 1'b1);
    chk_reg("t2_vec2", OFF_VEC, 32'h8000_0002);
    bus_write(OFF_VEC, 32'h0);
    chk_reg("t2_claim2", OFF_STAT, 32'h22);
    chk_reg("t2_pend_after_claim", OFF_PEND, 32'h20);
    bus_write(OFF_EOI, 32'h2);
    chk_reg("t2_eoi2", OFF_STAT, 32'h02);
    chk_irq("t2_eoi_irq", 1'b0);
    step(1);
    chk_irq("t2_reassert", 1'b1);
    chk_reg("t2_vec5", OFF_VEC, 32'h8000_0005);
    bus_write(OFF_VEC, 32'h0);
    chk_reg("t2_claim5", OFF_STAT, 32'h25);
    bus_write(OFF_EOI, 32'h5);
    chk_reg("t2_eoi5", OFF_STAT, 32'h05);

    // Rotating priority, level sources 0 and 3
    bus_write(OFF_MODE, 32'h00);
    bus_write(OFF_MASK, 32'h09);
    bus_write(OFF_CTRL, 32'h03);
    src_irq = 6'h09;
    step(1);
    chk_reg("t3_pend", OFF_PEND, 32'h09);
    step(1);
    chk_irq("t3_irq", 1'b1);
    chk_reg("t3_vec0", OFF_VEC, 32'h8000_0000);
    bus_write(OFF_VEC, 32'h0);
    bus_write(OFF_EOI, 32'h0);
    chk_reg("t3_level_pend", OFF_PEND, 32'h09);
    step(1);
    chk_irq("t3_reassert", 1'b1);
    chk_reg("t3_vec3", OFF_VEC, 32'h8000_0003);
    bus_write(OFF_VEC, 32'h0);
    chk_reg("t3_claim3", OFF_STAT, 32'h23);
    bus_write(OFF_EOI, 32'h3);
    step(1);
    chk_reg("t3_vec0_again", OFF_VEC, 32'h8000_0000);
    chk_reg("t3_assert_stat", OFF_STAT, 32'h13);

    // Mask-off in ASSERT: irq_out falls one edge later
    bus_write(OFF_MASK, 32'h00);
    chk_irq("t4_mask_j", 1'b1);
    step(1);
    chk_irq("t4_mask_j1", 1'b0);
    chk_reg("t4_stat_idle", OFF_STAT, 32'h03);
    chk_reg("t4_pend_kept", OFF_PEND, 32'h09);
    src_irq = 6'h00;

    // Mismatched EOI and stray claim set err
    bus_write(OFF_MASK, 32'h02);
    src_irq = 6'h02;
    step(2);
    chk_irq("t5_irq", 1'b1);
    chk_reg("t5_vec1", OFF_VEC, 32'h8000_0001);
    bus_write(OFF_VEC, 32'h0);
    chk_reg("t5_claim1", OFF_STAT, 32'h21);
    bus_write(OFF_EOI, 32'h4);
    chk_reg("t5_bad_eoi", OFF_STAT, 32'h121);
    bus_write(OFF_STAT, 32'h0);
    chk_reg("t5_err_clr", OFF_STAT, 32'h021);
    src_irq = 6'h00;
    step(1);
    bus_write(OFF_EOI, 32'h1);
    chk_reg("t5_eoi1", OFF_STAT, 32'h01);
    step(1);
    chk_irq("t5_idle_irq", 1'b0);
    bus_write(OFF_VEC, 32'h0);
    chk_reg("t5_idle_claim_err", OFF_STAT, 32'h101);
    bus_write(OFF_STAT, 32'h0);
    chk_reg("t5_err_clr2", OFF_STAT, 32'h001);

    // Edge and W1C in the same cycle: the set wins
    bus_write(OFF_MODE, 32'h02);
    src_irq = 6'h02;
    bus_write(OFF_PEND, 32'h02);
    chk_reg("t6_set_wins", OFF_PEND, 32'h02);
    bus_write(OFF_PEND, 32'h02);
    chk_reg("t6_w1c", OFF_PEND, 32'h00);
    src_irq = 6'h00;
    step(2);
    src_irq = 6'h02;
    step(2);
    chk_irq("t6_irq", 1'b1);
    bus_write(OFF_VEC, 32'h0);
    chk_reg("t6_service", OFF_STAT, 32'h21);

    // Asynchronous reset in SERVICE
    src_irq = 6'h00;
    rst = 1'b1;
    #1;
    chk_irq("t6_rst_irq", 1'b0);
    for (int a = 0; a < 8; a++) chk_reg($sformatf("t6_rst_rd%0d", a), 3'(a), 32'h0);
    step(1);
    rst = 1'b0;
    step(1);
    chk_irq("t6_post_rst_irq", 1'b0);
    chk_reg("t6_post_rst_stat", OFF_STAT, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Programmable interrupt controller placed between the peripheral `irq` lines (timer, UART, switch64, userkey and spares) and one CPU hardware interrupt input. It latches edge- or level-triggered requests, masks them, selects one winner by fixed or rotating priority, and sequences an assert/claim/end-of-interrupt handshake with the CPU. It is a bridge device, using the same addr/we/din/dout bus as the timer.

## Interface
- `NSRC`, 6: number of interrupt sources; legal range 1..8.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active-high
- `addr`  in  3  word offset from bridge `devaddr`
- `we`  in  1  register write strobe from bridge
- `din`  in  32  write data
- `dout`  out  32  read data, combinational from `addr`
- `src_irq`  in  NSRC  peripheral interrupt lines, synchronous to `clk`
- `irq_out`  out  1  registered interrupt request to CPU `hwint`

## Operation
- Registers, by word offset:
  - 0 PEND: read-only; bit i pending. A write clears every edge-mode bit whose `din` bit is 1 (W1C).
  - 1 MASK: R/W, bits [NSRC-1:0]; 1 = enabled.
  - 2 MODE: R/W; 1 = edge (rising), 0 = level.
  - 3 CTRL: R/W; bit0 = global enable, bit1 = rotating priority.
  - 4 VEC: read returns {valid[31], id[2:0]} of the current winner, with no side effect. Any write is a CLAIM.
  - 5 EOI: write `din[2:0]` = id; reads return 0.
  - 6 STAT: read returns {err[8], state[5:4], isr_id[2:0]}. Any write clears `err`.
  - 7: reads return 0; writes are ignored.
- Edge detection: `prev` register. If `src_irq & ~prev` in edge mode, the pend bit is set. In level mode the pend bit equals the registered `src_irq` every cycle.
- Qualified set = PEND & MASK, gated by CTRL.bit0.
- Winner selection:
  - Fixed mode: the lowest index wins.
  - Rotating mode: search starts at `base`; after an EOI for id k, `base` becomes (k+1) mod NSRC.
- State machine:
  - IDLE→ASSERT when the qualified set is nonzero.
  - ASSERT→IDLE if the qualified set becomes zero (mask change or W1C).
  - ASSERT→SERVICE on CLAIM. The winner is latched into `isr_id`, and an edge-mode pend bit for `isr_id` is cleared.
  - SERVICE→IDLE on an EOI whose id equals `isr_id`. An EOI with a mismatched id leaves the state unchanged and sets sticky `err`.
- No nesting: in SERVICE, new requests only accumulate in PEND.
- A CLAIM in IDLE or SERVICE, or an EOI outside SERVICE, is ignored and sets `err`.
- A set and a clear of the same pend bit in the same cycle: the set wins.
- Reset values: all registers 0, `base` 0, state IDLE, `irq_out` 0, `isr_id` 0, `err` 0, `prev` 0.

## Timing
- All register writes and state changes take effect on the rising `clk` edge in which `we` is high.
- `irq_out` is 1 exactly in state ASSERT and is registered.
- Latency: `src_irq` rises before edge k → pend bit is visible after edge k → `irq_out` rises after edge k+1.
- CLAIM at edge j → `irq_out` is 0 after edge j.
- EOI at edge j → state is IDLE after j. If a qualified request exists, `irq_out` rises after edge j+1.
- Mask-off of the last qualified source at edge j → `irq_out` falls after edge j+1.
- `rst` asserted mid-SERVICE: immediate asynchronous return to reset values; all pending requests are lost.

## Structure
- Package `irq_pkg` holds:
  - register offset constants (PEND..STAT);
  - the state encoding (IDLE=0, ASSERT=1, SERVICE=2);
  - the default NSRC.
- One sub-module, `irq_prio_enc`. It is a combinational rotating priority encoder with inputs req[NSRC], base and rot, and outputs valid and id.
- The top module holds the register file, edge detection and the FSM.

## Test plan
- Timer edge, source 0 edge-mode, MASK=1, CTRL=1: `src_irq[0]` pulses for 1 cycle → PEND=1, `irq_out` 1 two cycles later. CLAIM → `irq_out` 0, STAT.isr_id=0. EOI id 0 → IDLE, PEND=0.
- Fixed priority, sources 2 and 5 both pending: VEC=0x8000_0002. Serve 2 → `irq_out` reasserts with VEC=0x8000_0005.
- Rotating mode, sources 0 and 3 level-high: serve 0 → the next winner is 3, not 0. Serve 3 → the winner is 0.
- Level source stays high through EOI → PEND stays 1 and `irq_out` reasserts. Drop the level, then write MASK=0 in ASSERT → `irq_out` falls, state IDLE.
- EOI id 4 while `isr_id`=1 → state stays SERVICE, STAT.err=1. Write STAT → err=0.
- Edge on source 1 arriving in the same cycle as its W1C → pend bit remains 1. `rst` pulse in SERVICE → all reads 0, `irq_out`=0.
